// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: round-robin arbiter and sequencer for one single-port RAM.
// After reset it zero-fills the RAM, then gives two clients one access per
// cycle and routes each read response back to the client that issued it.
//
// Handshake: a request transfers on a rising edge where req_valid_x and
// req_ready_x are both high. req_ready_x is combinational, low outside RUN,
// and never depends on the other client being ready. A requester keeps
// valid/we/addr/wdata stable until the transfer. Responses have no
// backpressure: rsp_valid_x is a single-cycle pulse that must be consumed.
module mem_arb_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_rdata_0,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_rdata_1,
    output logic                  init_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  ptr;        // client that wins when both are valid
    logic                  in_run;
    logic                  grant_0;
    logic                  grant_1;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Read tag pipe: stage 1 follows the command register, stage 2 lines up
    // with the RAM output register.
    logic                  tag1_valid;
    logic                  tag1_id;
    logic                  tag2_valid;
    logic                  tag2_id;

    assign in_run = (state == ST_RUN);

    // Grant: a lone valid client wins; on contention the pointer decides.
    always_comb begin
        grant_0 = in_run & req_valid_0 & (~req_valid_1 | (ptr == 1'b0));
        grant_1 = in_run & req_valid_1 & (~req_valid_0 | (ptr == 1'b1));
    end

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign accept      = grant_0 | grant_1;

    // Mux the granted client's command onto the command register inputs.
    always_comb begin
        sel_we    = req_we_0;
        sel_addr  = req_addr_0;
        sel_wdata = req_wdata_0;
        if (grant_1) begin
            sel_we    = req_we_1;
            sel_addr  = req_addr_1;
            sel_wdata = req_wdata_1;
        end
    end

    // Sequencer FSM: walk every address in INIT, then stay in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT_EN ? ST_INIT : ST_RUN;
            init_done <= ~INIT_EN;
            init_cnt  <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end

    // Command register: zero-fill writes in INIT, accepted requests in RUN,
    // otherwise an idle read at the held address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (state == ST_INIT) begin
            mem_we   <= 1'b1;
            mem_addr <= init_cnt;
            mem_din  <= '0;
        end else if (accept) begin
            mem_we   <= sel_we;
            mem_addr <= sel_addr;
            mem_din  <= sel_wdata;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Round-robin pointer: after any grant, favour the other client.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (grant_0) begin
            ptr <= 1'b1;
        end else if (grant_1) begin
            ptr <= 1'b0;
        end
    end

    // Tag pipe: only accepted reads are tagged; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag1_valid <= 1'b0;
            tag1_id    <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_id    <= 1'b0;
        end else begin
            tag1_valid <= accept & ~sel_we;
            tag1_id    <= grant_1;
            tag2_valid <= tag1_valid;
            tag2_id    <= tag1_id;
        end
    end

    assign rsp_valid_0 = tag2_valid & ~tag2_id;
    assign rsp_valid_1 = tag2_valid & tag2_id;
    assign rsp_rdata_0 = mem_dout;
    assign rsp_rdata_1 = mem_dout;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: an 8-word instance with zero-fill backed
// by a behavioural registered-read RAM, plus a 4-word instance with
// zero-fill disabled.
module tb_mem_arb_ctrl;

    localparam int DW = 32;

    logic clk;
    logic rst_n;

    // 8-word instance (ADDR_WIDTH=3, INIT_EN=1)
    logic          v0, we0, v1, we1;
    logic [2:0]    a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rdy0, rdy1, rv0, rv1, init_done, mem_we;
    logic [DW-1:0] rd0, rd1, mem_din, mem_dout;
    logic [2:0]    mem_addr;
    logic [DW-1:0] ram [0:7];

    // 4-word instance (ADDR_WIDTH=2, INIT_EN=0)
    logic          n_v0, n_we0, n_v1, n_we1;
    logic [1:0]    n_a0, n_a1;
    logic [DW-1:0] n_d0, n_d1;
    logic          n_rdy0, n_rdy1, n_rv0, n_rv1, n_init_done, n_mem_we;
    logic [DW-1:0] n_rd0, n_rd1, n_mem_din, n_mem_dout;
    logic [1:0]    n_mem_addr;

    int errors = 0;
    int checks = 0;

    mem_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .INIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(v0), .req_ready_0(rdy0), .req_we_0(we0),
        .req_addr_0(a0), .req_wdata_0(d0),
        .req_valid_1(v1), .req_ready_1(rdy1), .req_we_1(we1),
        .req_addr_1(a1), .req_wdata_1(d1),
        .rsp_valid_0(rv0), .rsp_rdata_0(rd0),
        .rsp_valid_1(rv1), .rsp_rdata_1(rd1),
        .init_done(init_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    mem_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .INIT_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(n_v0), .req_ready_0(n_rdy0), .req_we_0(n_we0),
        .req_addr_0(n_a0), .req_wdata_0(n_d0),
        .req_valid_1(n_v1), .req_ready_1(n_rdy1), .req_we_1(n_we1),
        .req_addr_1(n_a1), .req_wdata_1(n_d1),
        .rsp_valid_0(n_rv0), .rsp_rdata_0(n_rd0),
        .rsp_valid_1(n_rv1), .rsp_rdata_1(n_rd1),
        .init_done(n_init_done),
        .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_din(n_mem_din),
        .mem_dout(n_mem_dout)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered read, read only when we=0.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        else        mem_dout      <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 0; we0 = 0; a0 = 0; d0 = 0;
        v1 = 0; we1 = 0; a1 = 0; d1 = 0;
        n_v0 = 1; n_we0 = 1; n_a0 = 2'd3; n_d0 = 32'h0000_00A5;
        n_v1 = 0; n_we1 = 0; n_a1 = 0; n_d1 = 0;
        n_mem_dout = '0;

        // Reset state
        step(); step();
        v0 = 1; v1 = 1;
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_rsp_valid_0", rv0, 0);
        chk("rst_rsp_valid_1", rv1, 0);
        chk("rst_ready_0", rdy0, 0);
        chk("noinit_rst_init_done", n_init_done, 1);
        rst_n = 1'b1;

        // Zero-fill: addresses 0..7, ready held low with both clients valid
        for (int i = 0; i < 8; i++) begin
            step();
            chk("init_mem_we", mem_we, 1);
            chk("init_mem_addr", mem_addr, i);
            chk("init_mem_din", mem_din, 0);
            chk("init_done_level", init_done, (i == 7));
            if (i == 0) begin
                chk("noinit_done", n_init_done, 1);
                chk("noinit_ready_0", n_rdy0, 1);
                chk("noinit_ready_1", n_rdy1, 0);
                chk("noinit_mem_we", n_mem_we, 1);
                chk("noinit_mem_addr", n_mem_addr, 3);
                chk("noinit_mem_din", n_mem_din, 32'h0000_00A5);
                n_v0 = 0;
            end
            if (i < 7) begin
                chk("init_ready_0", rdy0, 0);
                chk("init_ready_1", rdy1, 0);
            end else begin
                // First RUN cycle, both valid, pointer at client 0
                we0 = 1; a0 = 3'd5; d0 = 32'hDEAD_BEEF;
                we1 = 1; a1 = 3'd2; d1 = 32'h2222_2222;
                #1;
                chk("run_first_ready_0", rdy0, 1);
                chk("run_first_ready_1", rdy1, 0);
            end
        end

        // Write 5 presented; client 1 now wins contention
        step();
        chk("wr5_mem_we", mem_we, 1);
        chk("wr5_mem_addr", mem_addr, 5);
        chk("wr5_mem_din", mem_din, 32'hDEAD_BEEF);
        we0 = 0; a0 = 3'd5;
        #1;
        chk("rr_ready_1", rdy1, 1);
        chk("rr_ready_0", rdy0, 0);

        // Write 2 presented; client 0 alone
        step();
        chk("wr2_mem_we", mem_we, 1);
        chk("wr2_mem_addr", mem_addr, 2);
        chk("wr2_mem_din", mem_din, 32'h2222_2222);
        v1 = 0;
        #1;
        chk("rd5_ready_0", rdy0, 1);

        // Read 5 presented; client 1 reads addr 2
        step();
        chk("rd5_mem_we", mem_we, 0);
        chk("rd5_mem_addr", mem_addr, 5);
        v0 = 0;
        v1 = 1; we1 = 0; a1 = 3'd2;
        #1;
        chk("rd2_ready_1", rdy1, 1);

        // Response to read 5, two cycles after acceptance
        step();
        chk("rd5_rsp_valid_0", rv0, 1);
        chk("rd5_rsp_rdata_0", rd0, 32'hDEAD_BEEF);
        chk("rd5_rsp_valid_1", rv1, 0);
        chk("rd2_mem_addr", mem_addr, 2);
        we1 = 1; a1 = 3'd1; d1 = 32'h1111_1111;
        #1;
        chk("wr1_ready_1", rdy1, 1);

        // Response to read 2; then both clients read continuously
        step();
        chk("rd2_rsp_valid_1", rv1, 1);
        chk("rd2_rsp_rdata_1", rd1, 32'h2222_2222);
        chk("rd2_rsp_valid_0", rv0, 0);
        chk("wr1_mem_addr", mem_addr, 1);
        v0 = 1; we0 = 0; a0 = 3'd1;
        v1 = 1; we1 = 0; a1 = 3'd2;
        #1;
        chk("alt_ready_0_g0", rdy0, 1);
        chk("alt_ready_1_g0", rdy1, 0);

        for (int j = 1; j <= 8; j++) begin
            step();
            if (j <= 5) begin
                #1;
                chk("alt_ready_0", rdy0, (j % 2 == 0));
                chk("alt_ready_1", rdy1, (j % 2 == 1));
            end else if (j == 6) begin
                v0 = 0; v1 = 0;
                #1;
                chk("alt_idle_ready_0", rdy0, 0);
                chk("alt_idle_ready_1", rdy1, 0);
            end
            if (j >= 2 && j <= 7) begin
                chk("alt_rsp_valid_0", rv0, (j % 2 == 0));
                chk("alt_rsp_valid_1", rv1, (j % 2 == 1));
                if (j % 2 == 0) chk("alt_rsp_rdata_0", rd0, 32'h1111_1111);
                else            chk("alt_rsp_rdata_1", rd1, 32'h2222_2222);
            end else begin
                chk("alt_quiet_rsp_0", rv0, 0);
                chk("alt_quiet_rsp_1", rv1, 0);
            end
        end

        // Read of never-written addr 7 returns the zero-fill value
        step();
        v1 = 1; we1 = 0; a1 = 3'd7;
        #1;
        chk("rd7_ready_1", rdy1, 1);
        step();
        v1 = 0;
        chk("rd7_early_rsp", rv1, 0);
        step();
        chk("rd7_rsp_valid_1", rv1, 1);
        chk("rd7_rsp_rdata_1", rd1, 0);
        chk("rd7_rsp_valid_0", rv0, 0);

        // Reset with reads in flight: no responses, zero-fill restarts
        step();
        v0 = 1; we0 = 0; a0 = 3'd5;
        v1 = 1; we1 = 0; a1 = 3'd2;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        v1 = 0;
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_rsp_0", rv0, 0);
        chk("mid_rst_rsp_1", rv1, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("refill_rsp_0", rv0, 0);
            chk("refill_rsp_1", rv1, 0);
            chk("refill_mem_we", mem_we, 1);
            chk("refill_mem_addr", mem_addr, i);
            chk("refill_init_done", init_done, (i == 7));
            if (i < 7) chk("refill_ready_0", rdy0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
